spread_ctrl_2_2: RTL and testbench
==================================

Name: spread_ctrl_2_2

Overview:
- Inverse of the funnel control path: gathers narrow slot-wide beats from one or two requesters into a 4-slot wide word, then presents it downstream on a req/ack output.
- Slot fill order is bit-reversed state, matching the funnel's sel encoding, so a funnel→spread round trip restores lane order.
- Sits on the return path of the piston datapath; mode is loaded over a cfg handshake only on word boundaries.

Parameters:
- SLOT_W, 32, width of one slot / one narrow beat in bits
- NSLOT, 4, slots per wide word; fixed at 4 (2-bit state); other values unsupported

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- t_0_req  input  1  narrow beat valid, port 0
- t_0_ack  output  1  port 0 beat accepted this cycle
- t_0_data  input  SLOT_W  port 0 beat payload
- t_1_req  input  1  narrow beat valid, port 1 (used only in reduct 2)
- t_1_ack  output  1  port 1 beat accepted this cycle
- t_1_data  input  SLOT_W  port 1 beat payload
- t_cfg_req  input  1  mode load request
- t_cfg_ack  output  1  mode load accepted
- cfg_mode  input  8  new mode; only bits [1:0] (reduct) used
- o_req  output  1  wide word valid
- o_ack  input  1  downstream accepts wide word
- o_data  output  4*SLOT_W  wide word; slot i at bits [i*SLOT_W +: SLOT_W]
- sel  output  2  slot index for next port-0 beat = {state[0], state[1]}
- busy  output  1  (state != 0) | o_req

Behaviour:
- Reset: reset_n is the asynchronous, active-low reset; clk is the clock.
- Reset values: state=0, reduct_q=0, acc=0, o_req=0, o_data=0.
- A reset mid-word discards the partial word and any pending output word.
- reduct_q = 1: only port 0 is active, 1 slot per beat, 4 beats per word.
- reduct_q = 2: ports 0 and 1 are accepted together, 2 slots per beat, 2 beats per word.
- reduct_q = 0 or 3: idle. No beat acks, state frozen.
- state_nxt = state + reduct_q (2-bit wrap).
- last = (state_nxt == 0).
- room = ~last | ~o_req | o_ack (the output register is empty, or is drained this cycle).
- progress:
  - reduct 1: t_0_req & room
  - reduct 2: t_0_req & t_1_req & room
  - otherwise 0
- Beat acks: t_0_ack = progress; t_1_ack = progress & (reduct_q == 2).
  - Acks are combinational from reqs and o_ack.
  - Requesters must not make req depend on ack.
- Slot writes on progress:
  - port 0 writes slot bitrev(state).
  - reduct 2 only: port 1 writes slot bitrev(state+1).
  - state <= state_nxt.
- On the last beat (progress & last):
  - o_data <= acc merged with the incoming beat's slot(s), in the same cycle.
  - o_req <= 1.
  - acc is cleared to 0.
- Not the last beat: the slot(s) are written into acc.
- Output handshake: o_req & o_ack with no new last beat → o_req <= 0, and o_data holds.
  - Simultaneous o_ack and a new last beat: o_req stays 1 and o_data updates. Back-to-back words, zero bubble.
- Backpressure: while o_req & ~o_ack, non-last beats of the next word are still accepted. The last beat stalls with ack low.
- Cfg:
  - t_cfg_ack = (state == 0), combinational.
  - On t_cfg_req & t_cfg_ack: reduct_q <= cfg_mode[1:0].
  - The new mode takes effect next cycle. A beat accepted in the same cycle uses the old reduct_q.
  - A pending o_req does not block cfg.
- Data width: no arithmetic on payload; state arithmetic is 2-bit modulo.

Test Plan:
- After reset, o_req=0, busy=0, t_0_ack=0 with t_0_req=1 (reduct_q=0) → no acks for 10 cycles.
- Cfg reduct=1; stream A0,A1,A2,A3 on t_0, o_ack=1 → sel sequence 0,2,1,3.
  - One cycle after A3: o_req=1, o_data={A3,A1,A2,A0} (slot3..slot0).
- Cfg reduct=2; t_0/t_1 = (B0,B1) then (B2,B3) → t_1_ack high both beats.
  - o_data={B3,B1,B2,B0}; a port-1-only req gives no ack.
- reduct=1, o_ack=0 after first word → next word's beats 0..2 acked, beat 3 held unacked.
  - Raise o_ack → beat 3 acked the same cycle; o_data updates next cycle with o_req continuously 1.
- Cfg req at state=2 → t_cfg_ack=0 until the word's last beat; acked at state 0; a subsequent word uses the new reduct.
- Assert reset_n=0 asynchronously after 2 beats → all outputs 0 immediately; after release, a fresh 4-beat word assembles from slot 0 with no stale data.

Source files
------------

// File: rtl/spread_ctrl_2_2.sv
// spread_ctrl_2_2: gathers narrow slot beats from one or two ports into
// a 4-slot wide word, filling slots in bit-reversed state order.
module spread_ctrl_2_2 #(
    parameter int SLOT_W = 32,
    parameter int NSLOT  = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      t_0_req,
    output logic                      t_0_ack,
    input  logic [SLOT_W-1:0]         t_0_data,
    input  logic                      t_1_req,
    output logic                      t_1_ack,
    input  logic [SLOT_W-1:0]         t_1_data,
    input  logic                      t_cfg_req,
    output logic                      t_cfg_ack,
    input  logic [7:0]                cfg_mode,
    output logic                      o_req,
    input  logic                      o_ack,
    output logic [NSLOT*SLOT_W-1:0]   o_data,
    output logic [1:0]                sel,
    output logic                      busy
);

    localparam int WW = NSLOT * SLOT_W;

    logic [1:0]    state_q, state_d;
    logic [1:0]    reduct_q, reduct_d;
    logic [WW-1:0] acc_q, acc_d;
    logic [WW-1:0] o_data_q, o_data_d;
    logic          o_req_q, o_req_d;

    logic [1:0]    state_nxt;
    logic [1:0]    state_p1;
    logic [1:0]    slot0;
    logic [1:0]    slot1;
    logic          is_r2;
    logic          last;
    logic          room;
    logic          progress;
    logic          cfg_fire;
    logic [WW-1:0] merged;
    logic          unused_cfg;

    // Only the reduct field of the mode byte is meaningful.
    assign unused_cfg = ^cfg_mode[7:2];

    // Slot addressing and flow-control terms.
    assign state_nxt = state_q + reduct_q;
    assign state_p1  = state_q + 2'd1;
    assign slot0     = {state_q[0], state_q[1]};
    assign slot1     = {state_p1[0], state_p1[1]};
    assign is_r2     = (reduct_q == 2'd2);
    assign last      = (state_nxt == 2'd0);
    assign room      = ~last | ~o_req_q | o_ack;
    assign cfg_fire  = t_cfg_req & t_cfg_ack;

    // Beat acceptance depends on the active reduct.
    always_comb begin
        progress = 1'b0;
        unique case (reduct_q)
            2'd1:    progress = t_0_req & room;
            2'd2:    progress = t_0_req & t_1_req & room;
            default: progress = 1'b0;
        endcase
    end

    // Accumulator with this beat's slot(s) overlaid.
    always_comb begin
        merged = acc_q;
        merged[int'(slot0)*SLOT_W +: SLOT_W] = t_0_data;
        if (is_r2) begin
            merged[int'(slot1)*SLOT_W +: SLOT_W] = t_1_data;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= 2'd0;
            reduct_q <= 2'd0;
            acc_q    <= '0;
            o_data_q <= '0;
            o_req_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            reduct_q <= reduct_d;
            acc_q    <= acc_d;
            o_data_q <= o_data_d;
            o_req_q  <= o_req_d;
        end
    end

    // Next-state: advance on progress, emit the word on its last beat.
    always_comb begin
        state_d  = state_q;
        reduct_d = reduct_q;
        acc_d    = acc_q;
        o_data_d = o_data_q;
        o_req_d  = o_req_q;
        if (o_req_q && o_ack) begin
            o_req_d = 1'b0;
        end
        if (progress) begin
            state_d = state_nxt;
            if (last) begin
                o_data_d = merged;
                o_req_d  = 1'b1;
                acc_d    = '0;
            end else begin
                acc_d = merged;
            end
        end
        if (cfg_fire) begin
            reduct_d = cfg_mode[1:0];
        end
    end

    // Outputs.
    always_comb begin
        t_0_ack   = progress;
        t_1_ack   = progress & is_r2;
        t_cfg_ack = (state_q == 2'd0);
        o_req     = o_req_q;
        o_data    = o_data_q;
        sel       = slot0;
        busy      = (state_q != 2'd0) | o_req_q;
    end

endmodule

// File: tb/tb_spread_ctrl_2_2.sv
// tb_spread_ctrl_2_2: directed vector table plus hand sequences
// for idle mode and asynchronous reset mid-word.
module tb_spread_ctrl_2_2;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         t_0_req, t_1_req, t_cfg_req, o_ack;
    logic [31:0]  t_0_data, t_1_data;
    logic [7:0]   cfg_mode;
    logic         t_0_ack, t_1_ack, t_cfg_ack, o_req, busy;
    logic [127:0] o_data;
    logic [1:0]   sel;

    int checks = 0;
    int errors = 0;

    spread_ctrl_2_2 dut (
        .clk(clk), .reset_n(reset_n),
        .t_0_req(t_0_req), .t_0_ack(t_0_ack), .t_0_data(t_0_data),
        .t_1_req(t_1_req), .t_1_ack(t_1_ack), .t_1_data(t_1_data),
        .t_cfg_req(t_cfg_req), .t_cfg_ack(t_cfg_ack), .cfg_mode(cfg_mode),
        .o_req(o_req), .o_ack(o_ack), .o_data(o_data),
        .sel(sel), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         t0r;
        logic [31:0]  t0d;
        logic         t1r;
        logic [31:0]  t1d;
        logic         cr;
        logic [7:0]   cm;
        logic         oa;
        logic         e_t0a;
        logic         e_t1a;
        logic         e_ca;
        logic [1:0]   e_sel;
        logic         e_oreq;
        logic         e_busy;
        logic         chk_d;
        logic [127:0] e_data;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] w(input logic [7:0] tag, input logic [1:0] i);
        return {tag, 8'h00, 8'hC3, 6'h00, i};
    endfunction

    // Expected wide word: slot3..slot0 = x3, x1, x2, x0.
    function automatic logic [127:0] word4(input logic [7:0] tag);
        return {w(tag, 2'd3), w(tag, 2'd1), w(tag, 2'd2), w(tag, 2'd0)};
    endfunction

    function automatic vec_t mkv(
        input logic t0r, input logic [31:0] t0d,
        input logic t1r, input logic [31:0] t1d,
        input logic cr, input logic [7:0] cm, input logic oa,
        input logic e_t0a, input logic e_t1a, input logic e_ca,
        input logic [1:0] e_sel, input logic e_oreq, input logic e_busy,
        input logic chk_d, input logic [127:0] e_data);
        vec_t v;
        v.t0r = t0r; v.t0d = t0d; v.t1r = t1r; v.t1d = t1d;
        v.cr = cr; v.cm = cm; v.oa = oa;
        v.e_t0a = e_t0a; v.e_t1a = e_t1a; v.e_ca = e_ca; v.e_sel = e_sel;
        v.e_oreq = e_oreq; v.e_busy = e_busy;
        v.chk_d = chk_d; v.e_data = e_data;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic t0r, input logic [31:0] t0d,
                         input logic t1r, input logic [31:0] t1d,
                         input logic cr, input logic [7:0] cm, input logic oa);
        t_0_req = t0r; t_0_data = t0d;
        t_1_req = t1r; t_1_data = t1d;
        t_cfg_req = cr; cfg_mode = cm; o_ack = oa;
    endtask

    initial begin
        logic [127:0] wa, wb, wc, wd, we, wg;
        wa = word4(8'hA0); wb = word4(8'hB0); wc = word4(8'hC0);
        wd = word4(8'hD0); we = word4(8'hE0); wg = word4(8'h60);

        // t0r t0d t1r t1d cr cm oa | t0a t1a ca sel | oreq busy chk data
        tbl.push_back(mkv(0, 0, 0, 0, 1, 8'h01, 0, 0, 0, 1, 2'd0, 0, 0, 0, 0));
        tbl.push_back(mkv(1, w(8'hA0, 0), 0, 0, 0, 0, 1, 1, 0, 1, 2'd0, 0, 1, 0, 0));
        tbl.push_back(mkv(1, w(8'hA0, 1), 0, 0, 0, 0, 1, 1, 0, 0, 2'd2, 0, 1, 0, 0));
        tbl.push_back(mkv(1, w(8'hA0, 2), 0, 0, 0, 0, 1, 1, 0, 0, 2'd1, 0, 1, 0, 0));
        tbl.push_back(mkv(1, w(8'hA0, 3), 0, 0, 0, 0, 1, 1, 0, 0, 2'd3, 1, 1, 1, wa));
        tbl.push_back(mkv(0, 0, 0, 0, 1, 8'hFE, 1, 0, 0, 1, 2'd0, 0, 0, 1, wa));
        tbl.push_back(mkv(0, 0, 1, 32'hDEAD, 0, 0, 1, 0, 0, 1, 2'd0, 0, 0, 0, 0));
        tbl.push_back(mkv(1, w(8'hB0, 0), 1, w(8'hB0, 1), 0, 0, 1, 1, 1, 1, 2'd0, 0, 1, 0, 0));
        tbl.push_back(mkv(1, w(8'hB0, 2), 1, w(8'hB0, 3), 0, 0, 1, 1, 1, 0, 2'd1, 1, 1, 1, wb));
        tbl.push_back(mkv(0, 0, 0, 0, 1, 8'h01, 0, 0, 0, 1, 2'd0, 1, 1, 1, wb));
        tbl.push_back(mkv(1, w(8'hC0, 0), 0, 0, 0, 0, 0, 1, 0, 1, 2'd0, 1, 1, 1, wb));
        tbl.push_back(mkv(1, w(8'hC0, 1), 1, 32'h1, 0, 0, 0, 1, 0, 0, 2'd2, 1, 1, 1, wb));
        tbl.push_back(mkv(1, w(8'hC0, 2), 0, 0, 0, 0, 0, 1, 0, 0, 2'd1, 1, 1, 1, wb));
        tbl.push_back(mkv(1, w(8'hC0, 3), 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 1, 1, 1, wb));
        tbl.push_back(mkv(1, w(8'hC0, 3), 0, 0, 0, 0, 1, 1, 0, 0, 2'd3, 1, 1, 1, wc));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2'd0, 0, 0, 1, wc));
        tbl.push_back(mkv(1, w(8'hD0, 0), 0, 0, 0, 0, 1, 1, 0, 1, 2'd0, 0, 1, 0, 0));
        tbl.push_back(mkv(1, w(8'hD0, 1), 0, 0, 0, 0, 1, 1, 0, 0, 2'd2, 0, 1, 0, 0));
        tbl.push_back(mkv(1, w(8'hD0, 2), 0, 0, 1, 8'h02, 1, 1, 0, 0, 2'd1, 0, 1, 0, 0));
        tbl.push_back(mkv(1, w(8'hD0, 3), 0, 0, 1, 8'h02, 1, 1, 0, 0, 2'd3, 1, 1, 1, wd));
        tbl.push_back(mkv(0, 0, 0, 0, 1, 8'h02, 1, 0, 0, 1, 2'd0, 0, 0, 1, wd));
        tbl.push_back(mkv(1, w(8'hE0, 0), 1, w(8'hE0, 1), 0, 0, 1, 1, 1, 1, 2'd0, 0, 1, 0, 0));
        tbl.push_back(mkv(1, w(8'hE0, 2), 1, w(8'hE0, 3), 0, 0, 1, 1, 1, 0, 2'd1, 1, 1, 1, we));

        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        chk("reset o_req", o_req, 0);
        chk("reset busy", busy, 0);
        chk("reset o_data", o_data, 0);
        chk("reset sel", sel, 0);
        @(posedge clk);
        #1;

        // Idle mode: requests are never acknowledged.
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h1234, 1, 32'h5678, 0, 0, 1);
            #1;
            chk($sformatf("idle%0d t_0_ack", i), t_0_ack, 0);
            chk($sformatf("idle%0d t_1_ack", i), t_1_ack, 0);
            @(posedge clk);
            #1;
            chk($sformatf("idle%0d busy", i), busy, 0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].t0r, tbl[i].t0d, tbl[i].t1r, tbl[i].t1d,
                  tbl[i].cr, tbl[i].cm, tbl[i].oa);
            #1;
            chk($sformatf("v%0d t_0_ack", i), t_0_ack, tbl[i].e_t0a);
            chk($sformatf("v%0d t_1_ack", i), t_1_ack, tbl[i].e_t1a);
            chk($sformatf("v%0d t_cfg_ack", i), t_cfg_ack, tbl[i].e_ca);
            chk($sformatf("v%0d sel", i), sel, tbl[i].e_sel);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d o_req", i), o_req, tbl[i].e_oreq);
            chk($sformatf("v%0d busy", i), busy, tbl[i].e_busy);
            if (tbl[i].chk_d) begin
                chk($sformatf("v%0d o_data", i), o_data, tbl[i].e_data);
            end
        end

        // Drain the pending word and load reduct 1.
        drive(0, 0, 0, 0, 1, 8'h01, 1);
        @(posedge clk);
        #1;
        chk("rst pre o_req", o_req, 0);

        // Two beats, then asynchronous reset mid-word.
        for (int i = 0; i < 2; i++) begin
            drive(1, w(8'hF0, 2'(i)), 0, 0, 0, 0, 1);
            #1;
            chk($sformatf("rst beat%0d ack", i), t_0_ack, 1);
            @(posedge clk);
            #1;
        end
        chk("rst mid busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async o_req", o_req, 0);
        chk("async o_data", o_data, 0);
        chk("async busy", busy, 0);
        chk("async sel", sel, 0);
        chk("async t_0_ack", t_0_ack, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        drive(0, 0, 0, 0, 1, 8'h01, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            drive(1, w(8'h60, 2'(i)), 0, 0, 0, 0, 1);
            #1;
            chk($sformatf("fresh%0d ack", i), t_0_ack, 1);
            chk($sformatf("fresh%0d o_data", i), o_data, 0);
            @(posedge clk);
            #1;
        end
        chk("fresh o_req", o_req, 1);
        chk("fresh o_data word", o_data, wg);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
